// File: rtl/controle_partida_if.sv
// Signal bundle between the blackjack round controller and its scoring block / player panel.
// The master side is the controller; the slave side is the scoring block plus the player inputs.
interface controle_partida_if #(
    parameter int PW = 6
);
    logic          iniciar;
    logic          hit;
    logic          stay;
    logic          cartaok;
    logic [PW-1:0] pts_jogador;
    logic [PW-1:0] pts_dealer;
    logic          pjogador;
    logic          pdealer;
    logic [2:0]    ncartas_jog;
    logic [2:0]    ncartas_dealer;
    logic          vez_jogador;
    logic          vitoria;
    logic          derrota;
    logic          empate;
    logic          fim_jogo;

    modport master (
        input  iniciar, hit, stay, cartaok, pts_jogador, pts_dealer,
        output pjogador, pdealer, ncartas_jog, ncartas_dealer,
               vez_jogador, vitoria, derrota, empate, fim_jogo
    );

    modport slave (
        output iniciar, hit, stay, cartaok, pts_jogador, pts_dealer,
        input  pjogador, pdealer, ncartas_jog, ncartas_dealer,
               vez_jogador, vitoria, derrota, empate, fim_jogo
    );
endinterface

// File: rtl/controle_partida.sv
// Blackjack round controller: initial deal, player turn, dealer turn and final compare.
// One round per reset, since the scoring block only clears its points on reset.
module controle_partida #(
    parameter int PW           = 6,
    parameter int LIMITE       = 21,
    parameter int DEALER_STAND = 17,
    parameter int MAX_CARTAS   = 5
) (
    input  logic                clock,
    input  logic                reset,
    controle_partida_if.master  jogo
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] ESPERA_OK  = 3'd1;
    localparam logic [2:0] ESPERA_LIB = 3'd2;
    localparam logic [2:0] DECIDE     = 3'd3;
    localparam logic [2:0] VEZ_JOG    = 3'd4;
    localparam logic [2:0] VEZ_DEALER = 3'd5;
    localparam logic [2:0] FIM        = 3'd6;

    localparam logic          ALVO_JOG    = 1'b0;
    localparam logic          ALVO_DEALER = 1'b1;
    localparam logic [PW-1:0] LIMITE_C    = PW'(LIMITE);
    localparam logic [PW-1:0] STAND_C     = PW'(DEALER_STAND);
    localparam logic [2:0]    MAX_C       = 3'(MAX_CARTAS);

    logic [2:0] estado_q, estado_d;
    logic [2:0] cnt_q, cnt_d;
    logic       alvo_q, alvo_d;
    logic       pjog_q, pjog_d;
    logic       pdeal_q, pdeal_d;
    logic [2:0] ncj_q, ncj_d;
    logic [2:0] ncd_q, ncd_d;
    logic       vez_q, vez_d;
    logic       vit_q, vit_d;
    logic       der_q, der_d;
    logic       emp_q, emp_d;
    logic       fim_q, fim_d;

    logic jog_estoura_s, jog_para_s, dea_estoura_s;

    function automatic logic [2:0] inc_sat(input logic [2:0] v);
        if (v == 3'd7) begin
            return v;
        end else begin
            return v + 3'd1;
        end
    endfunction

    // Point evaluations, all unsigned PW-bit compares.
    always_comb begin
        jog_estoura_s = (jogo.pts_jogador > LIMITE_C);
        jog_para_s    = (jogo.pts_jogador == LIMITE_C) || (ncj_q == MAX_C);
        dea_estoura_s = (jogo.pts_dealer > LIMITE_C);
    end

    // Next-state and registered-output logic of the round sequencer.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        alvo_d   = alvo_q;
        pjog_d   = pjog_q;
        pdeal_d  = pdeal_q;
        ncj_d    = ncj_q;
        ncd_d    = ncd_q;
        vez_d    = vez_q;
        vit_d    = vit_q;
        der_d    = der_q;
        emp_d    = emp_q;
        fim_d    = fim_q;
        case (estado_q)
            IDLE: begin
                if (jogo.iniciar) begin
                    alvo_d   = ALVO_JOG;
                    pjog_d   = 1'b1;
                    estado_d = ESPERA_OK;
                end else begin
                    estado_d = IDLE;
                end
            end
            ESPERA_OK: begin
                if (jogo.cartaok) begin
                    pjog_d  = 1'b0;
                    pdeal_d = 1'b0;
                    if (alvo_q == ALVO_DEALER) begin
                        ncd_d = inc_sat(ncd_q);
                    end else begin
                        ncj_d = inc_sat(ncj_q);
                    end
                    estado_d = ESPERA_LIB;
                end else begin
                    estado_d = ESPERA_OK;
                end
            end
            ESPERA_LIB: begin
                if (!jogo.cartaok) begin
                    estado_d = DECIDE;
                end else begin
                    estado_d = ESPERA_LIB;
                end
            end
            DECIDE: begin
                if (cnt_q < 3'd4) begin
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    cnt_d = cnt_q;
                end
                // Cards 2..4 of the deal alternate D,J,D; the 4th card closes the deal.
                if (cnt_q < 3'd3) begin
                    alvo_d   = ~cnt_q[0];
                    pjog_d   = cnt_q[0];
                    pdeal_d  = ~cnt_q[0];
                    estado_d = ESPERA_OK;
                end else if ((cnt_q == 3'd3) || (alvo_q == ALVO_JOG)) begin
                    if (jog_estoura_s) begin
                        der_d    = 1'b1;
                        fim_d    = 1'b1;
                        estado_d = FIM;
                    end else if (jog_para_s) begin
                        estado_d = VEZ_DEALER;
                    end else begin
                        vez_d    = 1'b1;
                        estado_d = VEZ_JOG;
                    end
                end else begin
                    if (dea_estoura_s) begin
                        vit_d    = 1'b1;
                        fim_d    = 1'b1;
                        estado_d = FIM;
                    end else begin
                        estado_d = VEZ_DEALER;
                    end
                end
            end
            VEZ_JOG: begin
                if (jogo.stay) begin
                    vez_d    = 1'b0;
                    estado_d = VEZ_DEALER;
                end else if (jogo.hit) begin
                    vez_d    = 1'b0;
                    alvo_d   = ALVO_JOG;
                    pjog_d   = 1'b1;
                    estado_d = ESPERA_OK;
                end else begin
                    vez_d = 1'b1;
                end
            end
            VEZ_DEALER: begin
                if (jogo.pts_dealer < STAND_C) begin
                    alvo_d   = ALVO_DEALER;
                    pdeal_d  = 1'b1;
                    estado_d = ESPERA_OK;
                end else begin
                    if (jogo.pts_jogador > jogo.pts_dealer) begin
                        vit_d = 1'b1;
                    end else if (jogo.pts_jogador < jogo.pts_dealer) begin
                        der_d = 1'b1;
                    end else begin
                        emp_d = 1'b1;
                    end
                    fim_d    = 1'b1;
                    estado_d = FIM;
                end
            end
            FIM: begin
                estado_d = FIM;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset also drops any pending request asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= IDLE;
            cnt_q    <= 3'd0;
            alvo_q   <= ALVO_JOG;
            pjog_q   <= 1'b0;
            pdeal_q  <= 1'b0;
            ncj_q    <= 3'd0;
            ncd_q    <= 3'd0;
            vez_q    <= 1'b0;
            vit_q    <= 1'b0;
            der_q    <= 1'b0;
            emp_q    <= 1'b0;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            alvo_q   <= alvo_d;
            pjog_q   <= pjog_d;
            pdeal_q  <= pdeal_d;
            ncj_q    <= ncj_d;
            ncd_q    <= ncd_d;
            vez_q    <= vez_d;
            vit_q    <= vit_d;
            der_q    <= der_d;
            emp_q    <= emp_d;
            fim_q    <= fim_d;
        end
    end

    assign jogo.pjogador       = pjog_q;
    assign jogo.pdealer        = pdeal_q;
    assign jogo.ncartas_jog    = ncj_q;
    assign jogo.ncartas_dealer = ncd_q;
    assign jogo.vez_jogador    = vez_q;
    assign jogo.vitoria        = vit_q;
    assign jogo.derrota        = der_q;
    assign jogo.empate         = emp_q;
    assign jogo.fim_jogo       = fim_q;
endmodule
